// File: rtl/mem_pkg.sv
// mem_pkg: shared defaults, FSM states and index helper
// for the main_memory line store.
package mem_pkg;

  localparam int LINE_BITS_DEF = 128;
  localparam int LATENCY_DEF   = 10;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  function automatic int idx_bits(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array: single-port synchronous line store.
// Contents start at zero and are never touched by reset.
module mem_array #(
  parameter int W     = 128,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH] = '{default: '0};
  logic [W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/main_memory.sv
// main_memory: fixed-latency line memory, one request in flight.
// Define MAIN_MEMORY_WRITE_EN to let writes update storage.
module main_memory
  import mem_pkg::*;
#(
  parameter int LINE_BITS   = LINE_BITS_DEF,
  parameter int DEPTH_LINES = 1024,
  parameter int LATENCY     = LATENCY_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_req_valid,
  input  logic                 in_req_write,
  input  logic [31:0]          in_req_addr,
  input  logic [LINE_BITS-1:0] in_req_data,
  output logic                 out_req_ready,
  output logic                 out_resp_valid,
  output logic [LINE_BITS-1:0] out_resp_data,
  output logic                 out_busy
);

  localparam int IW = idx_bits(DEPTH_LINES);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [IW-1:0]        r_idx;
  logic                 r_wr;
  logic [LINE_BITS-1:0] r_wdata;
  logic [LINE_BITS-1:0] w_rdata;
  logic                 w_accept;
  logic                 w_access;
  logic                 w_arr_en;
  logic                 w_arr_we;
  logic                 w_unused;

  assign out_req_ready = (r_state == IDLE) && !reset;
  assign w_accept      = in_req_valid && out_req_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_access    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = BUSY;
          w_cnt_nxt   = '0;
        end
      end
      BUSY: begin
        if (r_cnt == CNT_LAST) begin
          w_access    = 1'b1;
          w_state_nxt = RESP;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_idx   <= in_req_addr[IW+3:4];
      r_wr    <= in_req_write;
      r_wdata <= in_req_data;
    end
  end

  // reset on the access edge aborts: no commit, no response
  assign w_arr_en = w_access && !reset;

`ifdef MAIN_MEMORY_WRITE_EN
  assign w_arr_we = w_arr_en && r_wr;
`else
  assign w_arr_we = 1'b0;
`endif

  mem_array #(
    .W     (LINE_BITS),
    .DEPTH (DEPTH_LINES),
    .AW    (IW)
  ) u_array (
    .clk     (clk),
    .i_en    (w_arr_en),
    .i_we    (w_arr_we),
    .i_addr  (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  assign out_busy       = (r_state == BUSY) || (r_state == RESP);
  assign out_resp_valid = (r_state == RESP);
  assign out_resp_data  = (out_resp_valid && !r_wr) ? w_rdata : '0;

  assign w_unused = ^{in_req_addr[31:IW+4], in_req_addr[3:0]};

endmodule

// File: tb/tb_main_memory.sv
// tb_main_memory: directed table, corner sequences and random
// traffic against a line-array model of main_memory.
module tb_main_memory;

  localparam int LB  = 128;
  localparam int DL  = 1024;
  localparam int LAT = 10;
`ifdef MAIN_MEMORY_WRITE_EN
  localparam bit WE = 1'b1;
`else
  localparam bit WE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_req_valid = 1'b0;
  logic          in_req_write = 1'b0;
  logic [31:0]   in_req_addr = '0;
  logic [LB-1:0] in_req_data = '0;
  logic          out_req_ready;
  logic          out_resp_valid;
  logic [LB-1:0] out_resp_data;
  logic          out_busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [LB-1:0] model [int];

  typedef struct {
    logic          wr;
    logic [31:0]   addr;
    logic [LB-1:0] data;
    logic [LB-1:0] exp;
  } vec_t;

  vec_t tv [7];

  main_memory #(
    .LINE_BITS   (LB),
    .DEPTH_LINES (DL),
    .LATENCY     (LAT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_req_valid   (in_req_valid),
    .in_req_write   (in_req_write),
    .in_req_addr    (in_req_addr),
    .in_req_data    (in_req_data),
    .out_req_ready  (out_req_ready),
    .out_resp_valid (out_resp_valid),
    .out_resp_data  (out_resp_data),
    .out_busy       (out_busy)
  );

  always #5 clk = ~clk;

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32'd16) % DL);
  endfunction

  function automatic logic [LB-1:0] peek(input int l);
    return model.exists(l) ? model[l] : '0;
  endfunction

  function automatic logic [LB-1:0] rand_lb();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string nm, input logic [LB-1:0] got,
                     input logic [LB-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // one full transaction; junk is driven on the inputs while busy
  task automatic xact(input logic wr, input logic [31:0] addr,
                      input logic [LB-1:0] d, input logic [LB-1:0] exp);
    int k;
    int lat;
    int busyc;
    int rdy_bad;
    bit seen;
    logic [LB-1:0] rd;
    @(negedge clk);
    in_req_valid = 1'b1;
    in_req_write = wr;
    in_req_addr  = addr;
    in_req_data  = d;
    k = 0;
    while (!out_req_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!out_req_ready) begin
      chk("ready_timeout", LB'(0), LB'(1));
      in_req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_req_valid = 1'($urandom);
    in_req_write = 1'($urandom);
    in_req_addr  = $urandom;
    in_req_data  = rand_lb();
    seen = 0; lat = 0; busyc = 0; rdy_bad = 0; rd = '0;
    for (int e = 1; e <= LAT + 6; e++) begin
      @(negedge clk);
      if (out_busy) busyc++;
      if (out_req_ready) rdy_bad++;
      if (out_resp_valid) begin
        seen = 1;
        lat = e - 1;
        rd = out_resp_data;
        in_req_valid = 1'b0;
        break;
      end
    end
    in_req_valid = 1'b0;
    if (!seen) begin
      chk("resp_timeout", LB'(0), LB'(1));
      return;
    end
    if (wr && WE) model[line_of(addr)] = d;
    chk("latency", LB'(lat), LB'(LAT));
    chk("busy_cycles", LB'(busyc), LB'(LAT + 1));
    chk("ready_while_busy", LB'(rdy_bad), LB'(0));
    chk("resp_data", rd, exp);
    @(negedge clk);
    chk("resp_one_cycle", LB'(out_resp_valid), LB'(0));
    chk("idle_ready", LB'(out_req_ready), LB'(1));
    chk("idle_busy", LB'(out_busy), LB'(0));
  endtask

  initial begin
    logic [LB-1:0] dA;
    logic [LB-1:0] dB;
    logic [LB-1:0] dC;
    logic [LB-1:0] dX;
    logic [31:0] a;
    logic w;
    int acc [$];
    int bad;
    int k;

    dA = 128'h0123456789ABCDEF0123456789ABCDEF;
    dB = 128'hA5A5A5A5_5A5A5A5A_DEADBEEF_00C0FFEE;
    dC = 128'hBBBB0000_1111CCCC_2222DDDD_3333EEEE;
    dX = 128'h77777777_00000007_FEDCBA98_76543210;

    tv[0] = '{1'b0, 32'h0000_0040, '0, '0};
    tv[1] = '{1'b1, 32'h0000_0040, dA, '0};
    tv[2] = '{1'b0, 32'h0000_004C, '0, WE ? dA : '0};
    tv[3] = '{1'b1, 32'h0000_4040, dB, '0};
    tv[4] = '{1'b0, 32'h0000_0040, '0, WE ? dB : '0};
    tv[5] = '{1'b1, 32'h0000_0070, dX, '0};
    tv[6] = '{1'b0, 32'h0000_0070, '0, WE ? dX : '0};

    repeat (3) @(negedge clk);
    chk("rst_ready", LB'(out_req_ready), LB'(0));
    chk("rst_busy", LB'(out_busy), LB'(0));
    chk("rst_resp_valid", LB'(out_resp_valid), LB'(0));
    chk("rst_resp_data", out_resp_data, '0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", LB'(out_req_ready), LB'(1));

    for (int i = 0; i < 7; i++)
      xact(tv[i].wr, tv[i].addr, tv[i].data, tv[i].exp);

    // continuous valid: acceptances every LAT+2 edges
    @(negedge clk);
    in_req_valid = 1'b1;
    in_req_write = 1'b0;
    in_req_addr  = 32'h0000_0100;
    bad = 0;
    for (int c = 0; c < 4 * (LAT + 2); c++) begin
      if (out_busy && out_req_ready) bad++;
      if (out_req_ready && in_req_valid) acc.push_back(c);
      @(negedge clk);
    end
    in_req_valid = 1'b0;
    chk("b2b_ready_in_busy", LB'(bad), LB'(0));
    chk("b2b_accept_count", LB'(acc.size()), LB'(4));
    for (int i = 1; i < acc.size(); i++)
      chk("b2b_spacing", LB'(acc[i] - acc[i-1]), LB'(LAT + 2));
    k = 0;
    while (out_busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_drain", LB'(out_busy), LB'(0));

    // reset at counter 5 of a write to line 3
    xact(1'b1, 32'h0000_0030, dC, '0);
    @(negedge clk);
    in_req_valid = 1'b1;
    in_req_write = 1'b1;
    in_req_addr  = 32'h0000_0030;
    in_req_data  = dB;
    @(posedge clk);
    #1;
    in_req_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_ready_in_rst", LB'(out_req_ready), LB'(0));
    @(negedge clk);
    chk("abort_busy", LB'(out_busy), LB'(0));
    chk("abort_resp_valid", LB'(out_resp_valid), LB'(0));
    chk("abort_resp_data", out_resp_data, '0);
    reset = 1'b0;
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_resp_valid) bad++;
    end
    chk("abort_no_resp", LB'(bad), LB'(0));
    xact(1'b0, 32'h0000_0030, '0, peek(3));

    // random traffic over a few lines, random offsets and aliases
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      a[13:4] = 10'($urandom_range(0, 7));
      w = 1'($urandom);
      dX = rand_lb();
      xact(w, a, dX, w ? '0 : peek(line_of(a)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
